// File: rtl/oled_power_sequencer.sv
// Power-up / init / power-down sequencer for the SSD1331 PMOD OLED.
// Drives the supply enables and the panel reset. Streams the fixed init command list to the
// SPI buffer over a valid/ready byte handshake. o_READY marks the window in which the display
// may be drawn to.
// Build option: define OLED_POWER_DOWN_EN to enable the i_POWER_OFF power-down sequence.
// Without it, S_READY is terminal until i_RST.
module oled_power_sequencer #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned T_VDD_MS = 20,
  parameter int unsigned T_RES_US = 3,
  parameter int unsigned T_VCC_MS = 25,
  parameter int unsigned T_ON_MS  = 100,
  parameter int unsigned T_OFF_MS = 400
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_POWER_ON,
  input  logic       i_POWER_OFF,
  input  logic       i_CMD_READY,
  output logic       o_CMD_VALID,
  output logic [7:0] o_CMD_BYTE,
  output logic       o_CMD_DC,
  output logic       o_RES,
  output logic       o_VCCEN,
  output logic       o_PMODEN,
  output logic       o_READY,
  output logic       o_BUSY
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned NVdd = CLK_HZ / 1000 * T_VDD_MS;
  localparam int unsigned NRes = CLK_HZ / 1_000_000 * T_RES_US;
  localparam int unsigned NVcc = CLK_HZ / 1000 * T_VCC_MS;
  localparam int unsigned NOn  = CLK_HZ / 1000 * T_ON_MS;

`ifdef OLED_POWER_DOWN_EN
  localparam int unsigned NOff = CLK_HZ / 1000 * T_OFF_MS;
  localparam int unsigned NMax = max_u(max_u(max_u(NVdd, NRes), max_u(NVcc, NOn)), NOff);
`else
  localparam int unsigned unused_t_off = T_OFF_MS;
  localparam int unsigned NMax = max_u(max_u(NVdd, NRes), max_u(NVcc, NOn));
`endif

  localparam int unsigned CW = (NMax > 1) ? $clog2(NMax) : 1;

  // A wait of N cycles leaves on the edge where the counter reads N-1.
  localparam logic [CW-1:0] LastVdd = CW'(NVdd - 1);
  localparam logic [CW-1:0] LastRes = CW'(NRes - 1);
  localparam logic [CW-1:0] LastVcc = CW'(NVcc - 1);
  localparam logic [CW-1:0] LastOn  = CW'(NOn - 1);
`ifdef OLED_POWER_DOWN_EN
  localparam logic [CW-1:0] LastOff = CW'(NOff - 1);
`endif

  localparam logic [5:0] LastIdx = 6'd38;

  localparam logic [3:0] S_OFF      = 4'd0;
  localparam logic [3:0] S_VDD_WAIT = 4'd1;
  localparam logic [3:0] S_RES_LOW  = 4'd2;
  localparam logic [3:0] S_RES_HIGH = 4'd3;
  localparam logic [3:0] S_INIT_CMD = 4'd4;
  localparam logic [3:0] S_VCC_WAIT = 4'd5;
  localparam logic [3:0] S_DISP_ON  = 4'd6;
  localparam logic [3:0] S_ON_WAIT  = 4'd7;
  localparam logic [3:0] S_READY    = 4'd8;
`ifdef OLED_POWER_DOWN_EN
  localparam logic [3:0] S_OFF_CMD  = 4'd9;
  localparam logic [3:0] S_OFF_WAIT = 4'd10;
`endif

  // SSD1331 init command list, sent in index order.
  function automatic logic [7:0] rom_byte(input logic [5:0] idx);
    case (idx)
      6'd0:  return 8'hFD;
      6'd1:  return 8'h12;
      6'd2:  return 8'hAE;
      6'd3:  return 8'hA0;
      6'd4:  return 8'h72;
      6'd5:  return 8'hA1;
      6'd6:  return 8'h00;
      6'd7:  return 8'hA2;
      6'd8:  return 8'h00;
      6'd9:  return 8'hA4;
      6'd10: return 8'hA8;
      6'd11: return 8'h3F;
      6'd12: return 8'hAD;
      6'd13: return 8'h8E;
      6'd14: return 8'hB0;
      6'd15: return 8'h0B;
      6'd16: return 8'hB1;
      6'd17: return 8'h31;
      6'd18: return 8'hB3;
      6'd19: return 8'hF0;
      6'd20: return 8'h8A;
      6'd21: return 8'h64;
      6'd22: return 8'h8B;
      6'd23: return 8'h78;
      6'd24: return 8'h8C;
      6'd25: return 8'h64;
      6'd26: return 8'hBB;
      6'd27: return 8'h3A;
      6'd28: return 8'hBE;
      6'd29: return 8'h3E;
      6'd30: return 8'h87;
      6'd31: return 8'h06;
      6'd32: return 8'h81;
      6'd33: return 8'h91;
      6'd34: return 8'h82;
      6'd35: return 8'h50;
      6'd36: return 8'h83;
      6'd37: return 8'h7D;
      6'd38: return 8'h2E;
      default: return 8'h00;
    endcase
  endfunction

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          res_q, res_d;
  logic          vccen_q, vccen_d;
  logic          pmoden_q, pmoden_d;
  logic          accept;

`ifndef OLED_POWER_DOWN_EN
  logic unused_power_off;
  assign unused_power_off = i_POWER_OFF;
`endif

  assign accept = valid_q & i_CMD_READY;

  // Next-state logic: sequence steps, delay counter and handshake bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    valid_d  = valid_q;
    byte_d   = byte_q;
    res_d    = res_q;
    vccen_d  = vccen_q;
    pmoden_d = pmoden_q;
    case (state_q)
      S_OFF: begin
        if (i_POWER_ON) begin
          state_d  = S_VDD_WAIT;
          pmoden_d = 1'b1;
        end
      end
      S_VDD_WAIT: begin
        if (cnt_q == LastVdd) begin
          state_d = S_RES_LOW;
          res_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RES_LOW: begin
        if (cnt_q == LastRes) begin
          state_d = S_RES_HIGH;
          res_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RES_HIGH: begin
        if (cnt_q == LastRes) begin
          state_d = S_INIT_CMD;
          idx_d   = '0;
          valid_d = 1'b1;
          byte_d  = rom_byte(6'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INIT_CMD: begin
        if (accept) begin
          if (idx_q == LastIdx) begin
            state_d = S_VCC_WAIT;
            valid_d = 1'b0;
            vccen_d = 1'b1;
          end else begin
            // Next byte follows immediately; VALID stays high.
            idx_d  = idx_q + 6'd1;
            byte_d = rom_byte(idx_q + 6'd1);
          end
        end
      end
      S_VCC_WAIT: begin
        if (cnt_q == LastVcc) begin
          state_d = S_DISP_ON;
          valid_d = 1'b1;
          byte_d  = 8'hAF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DISP_ON: begin
        if (accept) begin
          state_d = S_ON_WAIT;
          valid_d = 1'b0;
        end
      end
      S_ON_WAIT: begin
        if (cnt_q == LastOn) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READY: begin
`ifdef OLED_POWER_DOWN_EN
        if (i_POWER_OFF) begin
          state_d = S_OFF_CMD;
          valid_d = 1'b1;
          byte_d  = 8'hAE;
        end
`endif
      end
`ifdef OLED_POWER_DOWN_EN
      S_OFF_CMD: begin
        if (accept) begin
          state_d = S_OFF_WAIT;
          valid_d = 1'b0;
          vccen_d = 1'b0;
        end
      end
      S_OFF_WAIT: begin
        if (cnt_q == LastOff) begin
          state_d  = S_OFF;
          pmoden_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = S_OFF;
    endcase
  end

  // State and output registers; reset drops both supplies at once.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      byte_q   <= 8'h00;
      res_q    <= 1'b1;
      vccen_q  <= 1'b0;
      pmoden_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      byte_q   <= byte_d;
      res_q    <= res_d;
      vccen_q  <= vccen_d;
      pmoden_q <= pmoden_d;
    end
  end

  assign o_CMD_VALID = valid_q;
  assign o_CMD_BYTE  = byte_q;
  assign o_CMD_DC    = 1'b0;
  assign o_RES       = res_q;
  assign o_VCCEN     = vccen_q;
  assign o_PMODEN    = pmoden_q;
  assign o_READY     = (state_q == S_READY);
  assign o_BUSY      = (state_q != S_OFF) && (state_q != S_READY);

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Directed bench for oled_power_sequencer: reset values, power-up timing, init byte stream,
// handshake stalls, reset mid-init, ignored requests, and the power-down option when built
// with OLED_POWER_DOWN_EN.
module tb_oled_power_sequencer;

  // Millisecond delays are shortened so each power-up is about ten thousand cycles.
  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned T_VDD_MS = 2;
  localparam int unsigned T_RES_US = 3;
  localparam int unsigned T_VCC_MS = 3;
  localparam int unsigned T_ON_MS  = 5;
  localparam int unsigned T_OFF_MS = 4;

  localparam int NVdd = 2000;
  localparam int NRes = 3;
  localparam int NVcc = 3000;
  localparam int NOn  = 5000;
  localparam int NOff = 4000;

  logic       clk;
  logic       rst;
  logic       power_on;
  logic       power_off;
  logic       cmd_ready;
  logic       o_CMD_VALID;
  logic [7:0] o_CMD_BYTE;
  logic       o_CMD_DC;
  logic       o_RES;
  logic       o_VCCEN;
  logic       o_PMODEN;
  logic       o_READY;
  logic       o_BUSY;

  int passed;
  int total;
  logic [7:0] rom [39];

  oled_power_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .T_VDD_MS(T_VDD_MS),
    .T_RES_US(T_RES_US),
    .T_VCC_MS(T_VCC_MS),
    .T_ON_MS (T_ON_MS),
    .T_OFF_MS(T_OFF_MS)
  ) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_POWER_ON (power_on),
    .i_POWER_OFF(power_off),
    .i_CMD_READY(cmd_ready),
    .o_CMD_VALID(o_CMD_VALID),
    .o_CMD_BYTE (o_CMD_BYTE),
    .o_CMD_DC   (o_CMD_DC),
    .o_RES      (o_RES),
    .o_VCCEN    (o_VCCEN),
    .o_PMODEN   (o_PMODEN),
    .o_READY    (o_READY),
    .o_BUSY     (o_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until the selected output reaches val; -1 if the budget runs out.
  task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
    logic s;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      case (sel)
        0:       s = o_PMODEN;
        1:       s = o_RES;
        2:       s = o_VCCEN;
        3:       s = o_CMD_VALID;
        4:       s = o_READY;
        default: s = o_BUSY;
      endcase
      if (s === val) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    power_on  = 1'b0;
    power_off = 1'b0;
    cmd_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [8:0] got;
    power_on  = 1'b0;
    power_off = 1'b0;
    cmd_ready = 1'b0;
    rst       = 1'b0;
    #2 rst = 1'b1;
    #1;
    got = {o_RES, o_VCCEN, o_PMODEN, o_CMD_VALID, o_CMD_DC, o_READY, o_BUSY, 2'b00};
    total++;
    if (got !== 9'b1_0000_0000) $display("FAIL reset_ctrl: got %b expected %b", got, 9'b100000000);
    else passed++;
    total++;
    if (o_CMD_BYTE !== 8'h00) $display("FAIL reset_byte: got %h expected 00", o_CMD_BYTE);
    else passed++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_power_up_timing();
    int n;
    int bad;
    cmd_ready = 1'b1;
    power_on  = 1'b1;
    step();
    power_on = 1'b0;
    total++;
    if (o_PMODEN !== 1'b1 || o_BUSY !== 1'b1)
      $display("FAIL pmoden_rise: got pmoden=%b busy=%b expected 1 1", o_PMODEN, o_BUSY);
    else passed++;
    wait_sig(1, 1'b0, NVdd + 50, n);
    total++;
    if (n !== NVdd) $display("FAIL vdd_settle: got %0d expected %0d", n, NVdd);
    else passed++;
    wait_sig(1, 1'b1, NRes + 50, n);
    total++;
    if (n !== NRes) $display("FAIL res_low_width: got %0d expected %0d", n, NRes);
    else passed++;
    wait_sig(3, 1'b1, NRes + 50, n);
    total++;
    if (n !== NRes) $display("FAIL res_high_hold: got %0d expected %0d", n, NRes);
    else passed++;
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      if (o_CMD_VALID !== 1'b1 || o_CMD_BYTE !== rom[i]) begin
        $display("FAIL init_stream[%0d]: got valid=%b byte=%h expected 1 %h",
                 i, o_CMD_VALID, o_CMD_BYTE, rom[i]);
        bad++;
      end
      step();
    end
    total++;
    if (bad == 0) passed++;
    total++;
    if (o_CMD_VALID !== 1'b0 || o_VCCEN !== 1'b1 || o_CMD_DC !== 1'b0)
      $display("FAIL init_gap: got valid=%b vccen=%b dc=%b expected 0 1 0",
               o_CMD_VALID, o_VCCEN, o_CMD_DC);
    else passed++;
    wait_sig(3, 1'b1, NVcc + 50, n);
    total++;
    if (n !== NVcc || o_CMD_BYTE !== 8'hAF)
      $display("FAIL disp_on: got %0d cycles byte=%h expected %0d af", n, o_CMD_BYTE, NVcc);
    else passed++;
    step();
    total++;
    if (o_CMD_VALID !== 1'b0) $display("FAIL disp_on_accept: got valid=%b expected 0", o_CMD_VALID);
    else passed++;
    wait_sig(4, 1'b1, NOn + 50, n);
    total++;
    if (n !== NOn) $display("FAIL on_wait: got %0d expected %0d", n, NOn);
    else passed++;
    total++;
    if (o_BUSY !== 1'b0 || o_PMODEN !== 1'b1 || o_VCCEN !== 1'b1 || o_RES !== 1'b1)
      $display("FAIL ready_outputs: got busy=%b pmoden=%b vccen=%b res=%b expected 0 1 1 1",
               o_BUSY, o_PMODEN, o_VCCEN, o_RES);
    else passed++;
  endtask

`ifdef OLED_POWER_DOWN_EN
  task automatic test_power_down();
    int n;
    cmd_ready = 1'b0;
    power_off = 1'b1;
    step();
    power_off = 1'b0;
    total++;
    if (o_READY !== 1'b0 || o_CMD_VALID !== 1'b1 || o_CMD_BYTE !== 8'hAE || o_BUSY !== 1'b1)
      $display("FAIL off_cmd: got ready=%b valid=%b byte=%h busy=%b expected 0 1 ae 1",
               o_READY, o_CMD_VALID, o_CMD_BYTE, o_BUSY);
    else passed++;
    step();
    total++;
    if (o_CMD_VALID !== 1'b1 || o_CMD_BYTE !== 8'hAE || o_VCCEN !== 1'b1)
      $display("FAIL off_cmd_hold: got valid=%b byte=%h vccen=%b expected 1 ae 1",
               o_CMD_VALID, o_CMD_BYTE, o_VCCEN);
    else passed++;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    total++;
    if (o_CMD_VALID !== 1'b0 || o_VCCEN !== 1'b0 || o_PMODEN !== 1'b1)
      $display("FAIL off_accept: got valid=%b vccen=%b pmoden=%b expected 0 0 1",
               o_CMD_VALID, o_VCCEN, o_PMODEN);
    else passed++;
    wait_sig(0, 1'b0, NOff + 50, n);
    total++;
    if (n !== NOff) $display("FAIL off_wait: got %0d expected %0d", n, NOff);
    else passed++;
    total++;
    if (o_BUSY !== 1'b0 || o_READY !== 1'b0 || o_RES !== 1'b1)
      $display("FAIL off_state: got busy=%b ready=%b res=%b expected 0 0 1",
               o_BUSY, o_READY, o_RES);
    else passed++;
  endtask
`else
  task automatic test_ready_terminal();
    power_off = 1'b1;
    repeat (20) step();
    power_off = 1'b0;
    step();
    total++;
    if (o_READY !== 1'b1 || o_VCCEN !== 1'b1 || o_PMODEN !== 1'b1 || o_CMD_VALID !== 1'b0 ||
        o_BUSY !== 1'b0)
      $display("FAIL ready_terminal: got ready=%b vccen=%b pmoden=%b valid=%b busy=%b exp 1 1 1 0 0",
               o_READY, o_VCCEN, o_PMODEN, o_CMD_VALID, o_BUSY);
    else passed++;
  endtask
`endif

  task automatic test_busy_ignore();
    int n;
    int bad;
    do_reset();
    cmd_ready = 1'b1;
    power_on  = 1'b1;
    step();
    repeat (100) step();
    power_on = 1'b0;
    total++;
    if (o_PMODEN !== 1'b1 || o_BUSY !== 1'b1 || o_RES !== 1'b1)
      $display("FAIL busy_hold: got pmoden=%b busy=%b res=%b expected 1 1 1",
               o_PMODEN, o_BUSY, o_RES);
    else passed++;
    wait_sig(1, 1'b0, NVdd, n);
    total++;
    if (n !== NVdd - 100) $display("FAIL busy_vdd_timing: got %0d expected %0d", n, NVdd - 100);
    else passed++;
    power_on = 1'b1;
    wait_sig(1, 1'b1, NRes + 50, n);
    power_on = 1'b0;
    total++;
    if (n !== NRes) $display("FAIL busy_res_timing: got %0d expected %0d", n, NRes);
    else passed++;
    wait_sig(3, 1'b1, NRes + 50, n);
    total++;
    if (n !== NRes) $display("FAIL busy_init_start: got %0d expected %0d", n, NRes);
    else passed++;
    power_on = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_CMD_VALID !== 1'b1 || o_CMD_BYTE !== rom[i]) begin
        $display("FAIL busy_stream[%0d]: got valid=%b byte=%h expected 1 %h",
                 i, o_CMD_VALID, o_CMD_BYTE, rom[i]);
        bad++;
      end
      step();
    end
    power_on = 1'b0;
    total++;
    if (bad == 0) passed++;
  endtask

  task automatic test_stall();
    int n;
    int k;
    int stall_bad;
    int bad;
    logic [15:0] pat;
    logic        v;
    logic        r;
    logic [7:0]  b;
    logic [7:0]  got [39];
    do_reset();
    power_on = 1'b1;
    step();
    power_on = 1'b0;
    wait_sig(3, 1'b1, NVdd + 2 * NRes + 50, n);
    total++;
    if (n !== NVdd + 2 * NRes)
      $display("FAIL stall_start: got %0d expected %0d", n, NVdd + 2 * NRes);
    else passed++;
    pat       = 16'b1011_0010_1110_0101;
    k         = 0;
    stall_bad = 0;
    for (int c = 0; c < 400 && k < 39; c++) begin
      v = o_CMD_VALID;
      b = o_CMD_BYTE;
      r = pat[c % 16];
      cmd_ready = r;
      step();
      if (!v) begin
        stall_bad++;
      end else if (r) begin
        got[k] = b;
        k++;
      end else if (o_CMD_VALID !== 1'b1 || o_CMD_BYTE !== b) begin
        stall_bad++;
      end
    end
    cmd_ready = 1'b0;
    total++;
    if (stall_bad != 0) $display("FAIL stall_stable: got %0d violations expected 0", stall_bad);
    else passed++;
    total++;
    if (k != 39) $display("FAIL stall_count: got %0d bytes expected 39", k);
    else passed++;
    bad = 0;
    for (int i = 0; i < k; i++) begin
      if (got[i] !== rom[i]) begin
        $display("FAIL stall_scoreboard[%0d]: got %h expected %h", i, got[i], rom[i]);
        bad++;
      end
    end
    total++;
    if (bad == 0) passed++;
    total++;
    if (o_CMD_VALID !== 1'b0 || o_VCCEN !== 1'b1)
      $display("FAIL stall_end: got valid=%b vccen=%b expected 0 1", o_CMD_VALID, o_VCCEN);
    else passed++;
  endtask

  task automatic test_reset_mid_init();
    int n;
    do_reset();
    power_on = 1'b1;
    step();
    power_on = 1'b0;
    wait_sig(3, 1'b1, NVdd + 2 * NRes + 50, n);
    cmd_ready = 1'b1;
    repeat (10) step();
    cmd_ready = 1'b0;
    total++;
    if (n !== NVdd + 2 * NRes || o_CMD_VALID !== 1'b1 || o_CMD_BYTE !== 8'hA8)
      $display("FAIL mid_index10: got %0d cycles valid=%b byte=%h expected %0d 1 a8",
               n, o_CMD_VALID, o_CMD_BYTE, NVdd + 2 * NRes);
    else passed++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (o_PMODEN !== 1'b0 || o_VCCEN !== 1'b0 || o_CMD_VALID !== 1'b0 || o_RES !== 1'b1 ||
        o_BUSY !== 1'b0)
      $display("FAIL mid_async_reset: got pmoden=%b vccen=%b valid=%b res=%b busy=%b exp 0 0 0 1 0",
               o_PMODEN, o_VCCEN, o_CMD_VALID, o_RES, o_BUSY);
    else passed++;
    #1 rst = 1'b0;
    step();
    cmd_ready = 1'b1;
    power_on  = 1'b1;
    step();
    power_on = 1'b0;
    wait_sig(3, 1'b1, NVdd + 2 * NRes + 50, n);
    total++;
    if (n !== NVdd + 2 * NRes || o_CMD_BYTE !== 8'hFD)
      $display("FAIL repower_first: got %0d cycles byte=%h expected %0d fd",
               n, o_CMD_BYTE, NVdd + 2 * NRes);
    else passed++;
    step();
    total++;
    if (o_CMD_VALID !== 1'b1 || o_CMD_BYTE !== 8'h12)
      $display("FAIL repower_second: got valid=%b byte=%h expected 1 12", o_CMD_VALID, o_CMD_BYTE);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rom = '{8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
            8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0,
            8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E,
            8'h87, 8'h06, 8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E};
    test_reset();
    test_power_up_timing();
`ifdef OLED_POWER_DOWN_EN
    test_power_down();
`else
    test_ready_terminal();
`endif
    test_busy_ignore();
    test_stall();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
